// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
// Holds data width, funct3 encodings, FSM states and response error codes.
package mem_pkg;

    localparam int DWIDTH = 32;
    localparam logic [DWIDTH-1:0] ZERO = '0;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_RESP
    } lsu_state_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_FAULT    = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

endpackage

// File: rtl/lsu_lane_align.sv
// Lane steering: load extract/extend and sub-word store merge.
// Purely combinational; lane is the byte offset within the word.
module lsu_lane_align
    import mem_pkg::*;
(
    input  logic [DWIDTH-1:0] i_word,
    input  logic [15:0]       i_wdata,
    input  logic [1:0]        i_lane,
    input  logic [2:0]        i_funct3,
    output logic [DWIDTH-1:0] o_load,
    output logic [DWIDTH-1:0] o_store
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[{i_lane, 3'b000} +: 8];
        w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];

        case (i_funct3)
            F3_B:    o_load = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_load = {24'h000000, w_byte};
            F3_H:    o_load = {{16{w_half[15]}}, w_half};
            F3_HU:   o_load = {16'h0000, w_half};
            default: o_load = i_word;
        endcase

        o_store = i_word;
        case (i_funct3)
            F3_B: o_store[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
            F3_H: begin
                if (i_lane[1]) o_store[31:16] = i_wdata;
                else           o_store[15:0]  = i_wdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit in front of a word-only data memory.
// Sub-word stores go through a read-modify-write sequence.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int MEM_BYTES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [DWIDTH-1:0] req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DWIDTH-1:0] resp_rdata,
    output logic [1:0]        resp_err,
    output logic [DWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    output logic              mem_read_en,
    output logic              mem_write_en,
    input  logic [DWIDTH-1:0] mem_rdata
);

    localparam logic [DWIDTH-1:0] FAULT_BASE = DWIDTH'(MEM_BYTES - 3);

    lsu_state_t        r_state;
    lsu_state_t        w_next;
    logic              r_store;
    logic [2:0]        r_funct3;
    logic [1:0]        r_lane;
    logic [15:0]       r_wdata;
    logic [DWIDTH-1:0] r_mem_addr;
    logic [DWIDTH-1:0] r_mem_wdata;
    logic [DWIDTH-1:0] r_resp_rdata;
    logic [1:0]        r_resp_err;

    logic              w_accept;
    logic              w_legal;
    logic              w_mis;
    logic              w_fault;
    logic [1:0]        w_err;
    logic [DWIDTH-1:0] w_word_addr;
    logic [DWIDTH-1:0] w_load;
    logic [DWIDTH-1:0] w_store;

    assign w_accept = req_valid && (r_state == S_IDLE);

    always_comb begin
        w_word_addr = {req_addr[DWIDTH-1:2], 2'b00};
        w_legal = (req_funct3 == F3_B) || (req_funct3 == F3_H) ||
                  (req_funct3 == F3_W) ||
                  (!req_store && ((req_funct3 == F3_BU) ||
                                  (req_funct3 == F3_HU)));
        w_mis = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
        w_fault = (w_word_addr >= FAULT_BASE);
        // Illegal outranks misaligned, which outranks the range check
        if (!w_legal)    w_err = ERR_ILLEGAL;
        else if (w_mis)  w_err = ERR_MISALIGN;
        else if (w_fault) w_err = ERR_FAULT;
        else             w_err = ERR_NONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_err != ERR_NONE)
                        w_next = S_RESP;
                    else if (req_store && (req_funct3 == F3_W))
                        w_next = S_WRITE;
                    else
                        w_next = S_READ;
                end
            end
            S_READ:  w_next = r_store ? S_WRITE : S_RESP;
            S_WRITE: w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    lsu_lane_align u_align (
        .i_word   (mem_rdata),
        .i_wdata  (r_wdata),
        .i_lane   (r_lane),
        .i_funct3 (r_funct3),
        .o_load   (w_load),
        .o_store  (w_store)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_store      <= 1'b0;
            r_funct3     <= 3'b000;
            r_lane       <= 2'b00;
            r_wdata      <= 16'h0000;
            r_mem_addr   <= ZERO;
            r_mem_wdata  <= ZERO;
            r_resp_rdata <= ZERO;
            r_resp_err   <= ERR_NONE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_store  <= req_store;
                        r_funct3 <= req_funct3;
                        r_lane   <= req_addr[1:0];
                        r_wdata  <= req_wdata[15:0];
                        if (w_err != ERR_NONE) begin
                            r_resp_err   <= w_err;
                            r_resp_rdata <= ZERO;
                        end else begin
                            r_mem_addr <= w_word_addr;
                            if (req_store && (req_funct3 == F3_W))
                                r_mem_wdata <= req_wdata;
                        end
                    end
                end
                S_READ: begin
                    if (r_store) begin
                        r_mem_wdata <= w_store;
                    end else begin
                        r_resp_rdata <= w_load;
                        r_resp_err   <= ERR_NONE;
                    end
                end
                S_WRITE: begin
                    r_resp_rdata <= ZERO;
                    r_resp_err   <= ERR_NONE;
                end
                default: ;
            endcase
        end
    end

    assign req_ready    = (r_state == S_IDLE);
    assign resp_valid   = (r_state == S_RESP);
    assign mem_read_en  = (r_state == S_READ);
    assign mem_write_en = (r_state == S_WRITE);
    assign resp_rdata   = r_resp_rdata;
    assign resp_err     = r_resp_err;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: word-array memory, byte-level reference model,
// one per-cycle compare process plus literal expectations per transaction.
module tb_mem_access_unit;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [31:0] mem_rdata;

    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct {
        int          acc;
        int          rcyc;
        int          wcyc;
        logic        ren;
        logic        wen;
        logic [1:0]  err;
        logic [31:0] rdata;
        logic [31:0] waddr;
        logic [31:0] wdata;
    } exp_t;

    exp_t q[$];

    int          last_acc;
    int          last_rcyc;
    logic [1:0]  last_err;
    logic [31:0] last_rdata;
    logic [31:0] last_wdata;
    int          saw_en;

    mem_access_unit #(.MEM_BYTES(1024)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_store    (req_store),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_write_en) mem[mem_addr[9:2]] <= mem_wdata;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    function automatic int m_size(input logic st, input logic [2:0] f3);
        case (f3)
            3'd0: return 1;
            3'd1: return 2;
            3'd2: return 4;
            3'd4: return st ? 0 : 1;
            3'd5: return st ? 0 : 2;
            default: return 0;
        endcase
    endfunction

    function automatic logic [1:0] m_err(input logic st, input logic [2:0] f3,
                                         input logic [31:0] a);
        int sz;
        sz = m_size(st, f3);
        if (sz == 0) return 2'd3;
        if ((a % sz) != 0) return 2'd1;
        if ((a & ~32'd3) >= 32'd1021) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3,
                                           input logic [31:0] a);
        logic [31:0] v;
        v = ref_mem[a[9:2]] >> (8 * (a % 4));
        case (f3)
            3'd0: v = {{24{v[7]}}, v[7:0]};
            3'd4: v = {24'h0, v[7:0]};
            3'd1: v = {{16{v[15]}}, v[15:0]};
            3'd5: v = {16'h0, v[15:0]};
            default: ;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] m_merge(input int sz, input logic [31:0] a,
                                            input logic [31:0] wd);
        logic [31:0] w;
        int off;
        w = ref_mem[a[9:2]];
        off = a % 4;
        for (int i = 0; i < sz; i++) w[8*(off+i) +: 8] = wd[8*i +: 8];
        return w;
    endfunction

    // Per-cycle compare against the head of the expectation queue
    always @(negedge clk) begin
        if (!rst) begin
            chk("en_exclusive", {31'b0, mem_read_en && mem_write_en}, 32'd0);
            if (q.size() == 0) begin
                chk("idle_ready", {31'b0, req_ready}, 32'd1);
                chk("idle_ren", {31'b0, mem_read_en}, 32'd0);
                chk("idle_wen", {31'b0, mem_write_en}, 32'd0);
                chk("idle_resp", {31'b0, resp_valid}, 32'd0);
            end else begin
                exp_t e;
                e = q[0];
                chk("busy_ready", {31'b0, req_ready}, 32'd0);
                chk("ren", {31'b0, mem_read_en}, {31'b0, e.ren && cyc == e.acc});
                chk("wen", {31'b0, mem_write_en}, {31'b0, e.wen && cyc == e.wcyc});
                if (mem_read_en || mem_write_en) begin
                    saw_en++;
                    chk("mem_addr", mem_addr, e.waddr);
                end
                if (mem_write_en) begin
                    chk("mem_wdata", mem_wdata, e.wdata);
                    last_wdata = mem_wdata;
                end
                chk("resp_valid", {31'b0, resp_valid}, {31'b0, cyc == e.rcyc});
                if (resp_valid) begin
                    chk("resp_err", {30'b0, resp_err}, {30'b0, e.err});
                    chk("resp_rdata", resp_rdata, e.rdata);
                    last_rcyc = cyc;
                    last_err = resp_err;
                    last_rdata = resp_rdata;
                    void'(q.pop_front());
                end else if (cyc > e.rcyc) begin
                    chk("resp_timeout", 32'(cyc), 32'(e.rcyc));
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic send(input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input bit hold);
        exp_t e;
        int n;
        int sz;
        @(negedge clk);
        req_store = st;
        req_funct3 = f3;
        req_addr = a;
        req_wdata = wd;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 32'(n), 32'd0);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
        sz = m_size(st, f3);
        e.acc = cyc;
        e.err = m_err(st, f3, a);
        e.ren = (e.err == 2'd0) && (!st || sz < 4);
        e.wen = (e.err == 2'd0) && st;
        e.wcyc = cyc + ((sz < 4) ? 1 : 0);
        e.rcyc = cyc + ((e.err != 2'd0) ? 0 : (st && sz < 4) ? 2 : 1);
        e.rdata = (e.err != 2'd0 || st) ? 32'h0 : m_load(f3, a);
        e.waddr = a & ~32'd3;
        e.wdata = st ? m_merge(sz, a, wd) : 32'h0;
        if (e.wen) ref_mem[a[9:2]] = e.wdata;
        q.push_back(e);
        last_acc = cyc;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (q.size() != 0 && n < 30) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (q.size() != 0) begin
            chk("done_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
    endtask

    task automatic txn(input string nm, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] x_rdata, input logic [1:0] x_err,
                       input int x_lat);
        int en0;
        en0 = saw_en;
        send(st, f3, a, wd, 1'b0);
        wait_done();
        chk({nm, "_rdata"}, last_rdata, x_rdata);
        chk({nm, "_err"}, {30'b0, last_err}, {30'b0, x_err});
        chk({nm, "_lat"}, 32'(last_rcyc - last_acc + 1), 32'(x_lat));
        if (x_err != 2'd0) chk({nm, "_no_en"}, 32'(saw_en - en0), 32'd0);
    endtask

    initial begin
        int acc1;
        int acc2;
        int n;
        logic [31:0] saved;
        saw_en = 0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        mem[8] = 32'h000080FF;  ref_mem[8] = 32'h000080FF;
        mem[12] = 32'h11223344; ref_mem[12] = 32'h11223344;
        mem[16] = 32'hCAFEF00D; ref_mem[16] = 32'hCAFEF00D;

        #12;
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", {30'b0, resp_err}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_ren", {31'b0, mem_read_en}, 32'd0);
        chk("rst_wen", {31'b0, mem_write_en}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        txn("sw_10", 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 2'd0, 2);
        chk("sw_10_wdata", last_wdata, 32'hDEADBEEF);
        chk("sw_10_mem", mem[4], 32'hDEADBEEF);
        txn("lw_10", 1'b0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 2'd0, 2);
        txn("lb_21", 1'b0, 3'd0, 32'h21, 32'h0, 32'hFFFFFF80, 2'd0, 2);
        txn("lbu_21", 1'b0, 3'd4, 32'h21, 32'h0, 32'h00000080, 2'd0, 2);
        txn("lh_20", 1'b0, 3'd1, 32'h20, 32'h0, 32'hFFFF80FF, 2'd0, 2);
        txn("lhu_20", 1'b0, 3'd5, 32'h20, 32'h0, 32'h000080FF, 2'd0, 2);
        txn("lh_32", 1'b0, 3'd1, 32'h32, 32'h0, 32'h00001122, 2'd0, 2);
        txn("lb_33", 1'b0, 3'd0, 32'h33, 32'h0, 32'h00000011, 2'd0, 2);

        txn("sb_32", 1'b1, 3'd0, 32'h32, 32'h000000AA, 32'h0, 2'd0, 3);
        chk("sb_32_wdata", last_wdata, 32'h11AA3344);
        chk("sb_32_mem", mem[12], 32'h11AA3344);
        txn("sh_42", 1'b1, 3'd1, 32'h42, 32'h1234BEEF, 32'h0, 2'd0, 3);
        chk("sh_42_mem", mem[16], 32'hBEEFF00D);

        txn("lw_22", 1'b0, 3'd2, 32'h22, 32'h0, 32'h0, 2'd1, 1);
        txn("sh_31", 1'b1, 3'd1, 32'h31, 32'h0, 32'h0, 2'd1, 1);
        txn("lw_400", 1'b0, 3'd2, 32'h400, 32'h0, 32'h0, 2'd2, 1);
        txn("lb_3fd", 1'b0, 3'd0, 32'h3FD, 32'h0, 32'hFFFFFF00 & 32'h0, 2'd0, 2);
        txn("lw_3fe", 1'b0, 3'd2, 32'h3FE, 32'h0, 32'h0, 2'd1, 1);
        txn("st_f3_4", 1'b1, 3'd4, 32'h30, 32'h55, 32'h0, 2'd3, 1);
        txn("st_f3_5", 1'b1, 3'd5, 32'h31, 32'h55, 32'h0, 2'd3, 1);
        txn("ld_f3_3", 1'b0, 3'd3, 32'h10, 32'h0, 32'h0, 2'd3, 1);
        chk("err_mem_untouched", mem[12], 32'h11AA3344);

        send(1'b0, 3'd2, 32'h10, 32'h0, 1'b1);
        acc1 = last_acc;
        send(1'b0, 3'd2, 32'h30, 32'h0, 1'b1);
        acc2 = last_acc;
        chk("b2b_accept_1", 32'(acc2 - acc1), 32'd3);
        send(1'b1, 3'd0, 32'h11, 32'h77, 1'b0);
        chk("b2b_accept_2", 32'(last_acc - acc2), 32'd3);
        wait_done();
        chk("b2b_mem", mem[4], 32'hDEAD77EF);

        saved = ref_mem[16];
        send(1'b1, 3'd1, 32'h40, 32'h00005678, 1'b0);
        n = 0;
        while (!mem_write_en && n < 6) begin
            @(negedge clk);
            n++;
        end
        chk("rstmid_reached_write", {31'b0, mem_write_en}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid_wen", {31'b0, mem_write_en}, 32'd0);
        chk("rstmid_ren", {31'b0, mem_read_en}, 32'd0);
        chk("rstmid_resp", {31'b0, resp_valid}, 32'd0);
        chk("rstmid_ready", {31'b0, req_ready}, 32'd1);
        q.delete();
        ref_mem[16] = saved;
        @(negedge clk);
        #2;
        rst = 1'b0;
        chk("rstmid_mem", mem[16], 32'hBEEFF00D);
        repeat (4) @(negedge clk);
        txn("lw_40", 1'b0, 3'd2, 32'h40, 32'h0, 32'hBEEFF00D, 2'd0, 2);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
